ptcam: RTL and testbench
========================

Name: ptcam

Overview:
- Pseudo-ternary CAM: DEPTH entries of DATA_W-bit data plus one valid bit per entry.
- Provides bit-masked writes, an addressed read port and a masked (ternary-key) search.
- Search is sequential by default: one entry compared per clock, lowest address wins.
- Used as a small lookup table (e.g. MIDI note/channel matching) beside a controller that issues one search at a time.

Parameters:
- DEPTH, 16, number of entries (power of two)
- ADDR_W, 4, address width = log2(DEPTH)
- DATA_W, 19, entry / key width

Ports:
- clk  input  1  clock; all state changes on the rising edge
- reset_n  input  1  asynchronous reset, active-high (asserted = 1), per the already-decided convention; the codebase port name is kept
- w_addr  input  ADDR_W  write address
- w_din  input  DATA_W  write data
- w_mask  input  DATA_W  write bit-enable; 1 = update that bit
- w_en  input  1  write strobe
- r_addr  input  ADDR_W  read address
- r_dout  output  DATA_W  registered read data
- search_din  input  DATA_W  search key
- search_mask  input  DATA_W  care mask; 1 = compare that bit, 0 = don't care
- search_en  input  1  search start pulse
- search_valid  output  1  one-cycle result strobe
- search_dout  output  DATA_W  stored data of the matching entry
- search_addr_out  output  ADDR_W  address of the matching entry
- search_notfound  output  1  1 = no valid entry matched

Behaviour:
- Reset (asynchronous, level): all entry data = 0, all valid bits = 0, FSM = IDLE, scan index = 0, all outputs 0.
- Write: on an edge with w_en=1, mem[w_addr] <= (mem & ~w_mask) | (w_din & w_mask), and valid[w_addr] <= 1.
  - Any write sets the valid bit, even when w_mask = 0.
  - Entries are never invalidated except by reset.
- Read: r_dout <= mem[r_addr] every edge, so there is 1-cycle latency.
  - A same-cycle write to the same address returns the old data.
- Match rule for entry i: valid[i] && ((mem[i] ^ key) & mask) == 0.
- Search FSM states:
  - IDLE: on an edge with search_en=1, latch search_din and search_mask, set idx = 0, go to SCAN.
  - SCAN: each cycle compare entry idx against the latched key/mask.
    - On a hit: register search_dout = mem[idx], search_addr_out = idx, search_notfound = 0, pulse search_valid; go to IDLE.
    - On a miss at idx = DEPTH-1: register search_dout = 0, search_addr_out = 0, search_notfound = 1, pulse search_valid; go to IDLE.
    - Otherwise idx++.
- Latency: search_en sampled at edge E0; a hit at address k gives search_valid high after edge E0+1+k. A miss gives search_valid high after edge E0+DEPTH.
- search_valid is high for exactly one cycle.
- search_dout, search_addr_out and search_notfound hold their values until the next result.
- search_en while in SCAN is ignored; the latched key is unchanged.
- Writes during SCAN are allowed. Comparison uses the array contents at the cycle each entry is compared, so entries already passed are not rescanned.
- Multiple hits: the lowest address wins.
- All-zero search_mask matches the first valid entry, or returns notfound if no entry is valid.
- Reset during SCAN aborts the search; no search_valid pulse is produced.

Optional Feature:
- Macro PTCAM_PARALLEL_SEARCH_EN.
- When defined: all DEPTH entries are compared combinationally against search_din/search_mask on the search_en edge, and a priority encoder selects the lowest hit. The result and search_valid are registered and appear after edge E0+1 for both hit and miss. There is no SCAN state.
- When undefined: the sequential scan above.
- Match rule, priority, output hold and port list are identical in both builds.

Test Plan:
- After reset, search key 0x00000, mask 0x7FFFF -> search_valid=1, search_notfound=1, search_addr_out=0, search_dout=0.
- Write 0x00ABC to addr 7 and 0x00DEF to addr 15 (mask all ones); search 0x00ABC -> addr 7, dout 0x00ABC, notfound 0, valid after E0+8 (sequential build).
- Search 0x00DEF -> addr 15, dout 0x00DEF; search 0x0000C with mask 0x0000F -> addr 7 (lowest of the hits), dout 0x00ABC.
- r_addr=7, then r_addr=15 -> r_dout reads 0x00ABC, then 0x00DEF, each one cycle after the address is applied.
- Masked write: addr 15, din 0x00123, mask 0x0000F -> r_dout(15)=0x00DE3; search 0x00DEF with full mask -> notfound.
- Pulse search_en again during SCAN, and assert reset mid-scan -> the second pulse is ignored and only one result is produced; after reset, no valid pulse and all entries are cleared.

Source files
------------

// File: rtl/ptcam.sv
// ptcam: pseudo-ternary CAM with masked writes, registered read and masked search (PTCAM_PARALLEL_SEARCH_EN selects single-cycle search)
module ptcam #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4,
    parameter int DATA_W = 19
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] w_addr,
    input  logic [DATA_W-1:0] w_din,
    input  logic [DATA_W-1:0] w_mask,
    input  logic              w_en,
    input  logic [ADDR_W-1:0] r_addr,
    output logic [DATA_W-1:0] r_dout,
    input  logic [DATA_W-1:0] search_din,
    input  logic [DATA_W-1:0] search_mask,
    input  logic              search_en,
    output logic              search_valid,
    output logic [DATA_W-1:0] search_dout,
    output logic [ADDR_W-1:0] search_addr_out,
    output logic              search_notfound
);
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  valid;
    logic              sv_n, snf_n;
    logic [DATA_W-1:0] sd_n;
    logic [ADDR_W-1:0] sa_n;

    // storage: bit-masked write, any write marks the entry valid
    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            valid <= '0;
        end else if (w_en) begin
            mem[w_addr]   <= (mem[w_addr] & ~w_mask) | (w_din & w_mask);
            valid[w_addr] <= 1'b1;
        end
    end

    // read port: one-cycle latency, old data on a same-address write
    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) r_dout <= '0;
        else         r_dout <= mem[r_addr];
    end

`ifdef PTCAM_PARALLEL_SEARCH_EN
    // compare every entry on the start pulse; descending loop leaves the lowest hit
    always_comb begin
        sv_n  = 1'b0;
        sd_n  = search_dout;
        sa_n  = search_addr_out;
        snf_n = search_notfound;
        if (search_en) begin
            sv_n  = 1'b1;
            sd_n  = '0;
            sa_n  = '0;
            snf_n = 1'b1;
            for (int i = DEPTH - 1; i >= 0; i--)
                if (valid[i] && ((mem[i] ^ search_din) & search_mask) == '0) begin
                    sd_n  = mem[i];
                    sa_n  = ADDR_W'(i);
                    snf_n = 1'b0;
                end
        end
    end
`else
    typedef enum logic {IDLE, SCAN} state_t;
    state_t            state, state_n;
    logic [ADDR_W-1:0] idx, idx_n;
    logic [DATA_W-1:0] key, key_n, kmask, kmask_n;
    logic              hit;

    assign hit = valid[idx] && ((mem[idx] ^ key) & kmask) == '0;

    // scan state: latched key/mask and the entry index under comparison
    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            state <= IDLE;
            idx   <= '0;
            key   <= '0;
            kmask <= '0;
        end else begin
            state <= state_n;
            idx   <= idx_n;
            key   <= key_n;
            kmask <= kmask_n;
        end
    end

    // one entry per cycle, first hit ends the scan; start pulses during a scan are dropped
    always_comb begin
        state_n = state;
        idx_n   = idx;
        key_n   = key;
        kmask_n = kmask;
        sv_n    = 1'b0;
        sd_n    = search_dout;
        sa_n    = search_addr_out;
        snf_n   = search_notfound;
        if (state == IDLE) begin
            if (search_en) begin
                key_n   = search_din;
                kmask_n = search_mask;
                idx_n   = '0;
                state_n = SCAN;
            end
        end else if (hit) begin
            sv_n    = 1'b1;
            sd_n    = mem[idx];
            sa_n    = idx;
            snf_n   = 1'b0;
            state_n = IDLE;
        end else if (idx == ADDR_W'(DEPTH - 1)) begin
            sv_n    = 1'b1;
            sd_n    = '0;
            sa_n    = '0;
            snf_n   = 1'b1;
            state_n = IDLE;
        end else begin
            idx_n = idx + ADDR_W'(1);
        end
    end
`endif

    // result registers: strobe for one cycle, data held until the next result
    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            search_valid    <= 1'b0;
            search_dout     <= '0;
            search_addr_out <= '0;
            search_notfound <= 1'b0;
        end else begin
            search_valid    <= sv_n;
            search_dout     <= sd_n;
            search_addr_out <= sa_n;
            search_notfound <= snf_n;
        end
    end
endmodule

// File: tb/tb_ptcam.sv
// tb_ptcam: directed scoreboard bench for ptcam (sequential search build)
module tb_ptcam;
    localparam int DEPTH = 16, ADDR_W = 4, DATA_W = 19;
    localparam logic [DATA_W-1:0] ALL = 19'h7FFFF;

    logic              clk = 1'b0, reset_n = 1'b1;
    logic [ADDR_W-1:0] w_addr = '0, r_addr = '0;
    logic [DATA_W-1:0] w_din = '0, w_mask = '0, search_din = '0, search_mask = '0;
    logic              w_en = 1'b0, search_en = 1'b0;
    logic [DATA_W-1:0] r_dout, search_dout;
    logic [ADDR_W-1:0] search_addr_out;
    logic              search_valid, search_notfound;

    typedef struct {int addr; int dout; int nf; int cyc;} exp_t;
    exp_t q[$];
    int cyc = 0, n_chk = 0, n_err = 0;

    ptcam #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .reset_n(reset_n),
        .w_addr(w_addr), .w_din(w_din), .w_mask(w_mask), .w_en(w_en),
        .r_addr(r_addr), .r_dout(r_dout),
        .search_din(search_din), .search_mask(search_mask), .search_en(search_en),
        .search_valid(search_valid), .search_dout(search_dout),
        .search_addr_out(search_addr_out), .search_notfound(search_notfound)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // scoreboard: every result strobe must match the oldest pending search
    always @(negedge clk) begin
        if (!reset_n && search_valid) begin
            check("valid_expected", 32'(q.size() != 0), 32'd1);
            if (q.size() != 0) begin
                exp_t e;
                e = q.pop_front();
                check("s_addr", 32'(search_addr_out), e.addr);
                check("s_dout", 32'(search_dout), e.dout);
                check("s_nf", 32'(search_notfound), e.nf);
                check("s_latency", cyc, e.cyc);
            end
        end
    end

    task automatic wr(input int a, input logic [DATA_W-1:0] d, input logic [DATA_W-1:0] m);
        @(negedge clk);
        w_addr = ADDR_W'(a); w_din = d; w_mask = m; w_en = 1'b1;
        @(negedge clk);
        w_en = 1'b0;
    endtask

    task automatic rd(input int a, input logic [DATA_W-1:0] exp, input string tag);
        @(negedge clk);
        r_addr = ADDR_W'(a);
        @(negedge clk);
        check(tag, 32'(r_dout), 32'(exp));
    endtask

    task automatic start(input logic [DATA_W-1:0] k, input logic [DATA_W-1:0] m,
                         input int ea, input int ed, input int enf);
        @(negedge clk);
        search_din = k; search_mask = m; search_en = 1'b1;
        q.push_back('{ea, ed, enf, enf != 0 ? cyc + 1 + DEPTH : cyc + 2 + ea});
        @(negedge clk);
        search_en = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 40 && q.size() != 0; i++) @(negedge clk);
        check("search_timeout", 32'(q.size() == 0), 32'd1);
    endtask

    task automatic search(input logic [DATA_W-1:0] k, input logic [DATA_W-1:0] m,
                          input int ea, input int ed, input int enf);
        start(k, m, ea, ed, enf);
        wait_done();
    endtask

    initial begin
        repeat (2) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        check("rst_r_dout", 32'(r_dout), 0);
        check("rst_valid", 32'(search_valid), 0);
        check("rst_nf", 32'(search_notfound), 0);
        check("rst_addr", 32'(search_addr_out), 0);
        check("rst_dout", 32'(search_dout), 0);
        search(19'h0, ALL, 0, 0, 1);
        wr(7, 19'h00ABC, ALL);
        wr(15, 19'h00DEF, ALL);
        search(19'h00ABC, ALL, 7, 'hABC, 0);
        search(19'h00DEF, ALL, 15, 'hDEF, 0);
        search(19'h0000C, 19'h0000F, 7, 'hABC, 0);
        search(19'h12345, 19'h0, 7, 'hABC, 0);
        rd(7, 19'h00ABC, "rd7");
        rd(15, 19'h00DEF, "rd15");
        wr(15, 19'h00123, 19'h0000F);
        rd(15, 19'h00DE3, "rd15_masked");
        search(19'h00DEF, ALL, 0, 0, 1);
        wr(2, 19'h7FFFF, 19'h0);
        search(19'h0, ALL, 2, 0, 0);
        @(negedge clk);
        r_addr = 4'd15; w_addr = 4'd15; w_din = ALL; w_mask = ALL; w_en = 1'b1;
        @(negedge clk);
        w_en = 1'b0;
        check("rd_old_on_write", 32'(r_dout), 32'h00DE3);
        @(negedge clk);
        check("rd_new_after_write", 32'(r_dout), 32'h7FFFF);
        start(ALL, ALL, 15, 'h7FFFF, 0);
        repeat (2) @(negedge clk);
        search_din = 19'h0; search_mask = 19'h0; search_en = 1'b1;
        @(negedge clk);
        search_en = 1'b0;
        wait_done();
        repeat (20) @(negedge clk);
        start(19'h55555, ALL, 0, 0, 1);
        repeat (4) @(negedge clk);
        reset_n = 1'b1;
        q.delete();
        @(negedge clk);
        check("abort_valid", 32'(search_valid), 0);
        check("abort_nf", 32'(search_notfound), 0);
        reset_n = 1'b0;
        repeat (20) @(negedge clk);
        rd(7, 19'h0, "rd7_cleared");
        rd(15, 19'h0, "rd15_cleared");
        search(19'h0, 19'h0, 0, 0, 1);
        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end
endmodule
